// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - I2S (Philips) stereo transmitter with double-buffered sample holding and underrun flag.
// Build option: define I2S_TX_LJ_EN for left-justified output (no one-BCLK data delay).
module i2s_audio_tx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int BCLK_DIV     = 4
) (
  input  logic                    sCLK_XVXENVS,
  input  logic                    reset_reg_N,
  input  logic                    tx_en,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] lsound_in,
  input  logic [SAMPLE_WIDTH-1:0] rsound_in,
  output logic                    i2s_bclk,
  output logic                    i2s_lrck,
  output logic                    i2s_data,
  output logic                    sample_req,
  output logic                    underrun
);

  localparam int FRAME_W = 2 * SLOT_WIDTH;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int DIV_W   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int PAD     = SLOT_WIDTH - SAMPLE_WIDTH;

  logic [DIV_W-1:0]        div_cnt;
  logic                    bclk_q;
  logic                    lrck_q;
  logic [CNT_W-1:0]        bit_cnt;
  logic [FRAME_W-1:0]      shift_q;
  logic [SAMPLE_WIDTH-1:0] hold_l;
  logic [SAMPLE_WIDTH-1:0] hold_r;
  logic                    fresh_q;
  logic                    first_q;
  logic                    req_q;
  logic                    urun_q;
`ifndef I2S_TX_LJ_EN
  logic                    dly_q;
`endif

  logic                    tick;
  logic                    fall;
  logic                    frame_start;
  logic [SAMPLE_WIDTH-1:0] load_l;
  logic [SAMPLE_WIDTH-1:0] load_r;
  logic [SLOT_WIDTH-1:0]   slot_l;
  logic [SLOT_WIDTH-1:0]   slot_r;
  logic [CNT_W-1:0]        next_cnt;

  // A strobe landing on the frame-start clock bypasses the holding regs straight into the frame.
  always_comb begin
    tick        = tx_en && (div_cnt == DIV_W'(BCLK_DIV - 1));
    fall        = tick && bclk_q;
    frame_start = fall && (first_q || (bit_cnt == CNT_W'(FRAME_W - 1)));
    load_l      = sample_valid ? lsound_in : hold_l;
    load_r      = sample_valid ? rsound_in : hold_r;
    slot_l      = SLOT_WIDTH'(load_l) << PAD;
    slot_r      = SLOT_WIDTH'(load_r) << PAD;
    next_cnt    = bit_cnt + CNT_W'(1);
  end

  always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      div_cnt <= '0;
      bclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
      bit_cnt <= '0;
      shift_q <= '0;
      hold_l  <= '0;
      hold_r  <= '0;
      fresh_q <= 1'b0;
      first_q <= 1'b1;
      req_q   <= 1'b0;
      urun_q  <= 1'b0;
`ifndef I2S_TX_LJ_EN
      dly_q   <= 1'b0;
`endif
    end else begin
      req_q  <= 1'b0;
      urun_q <= 1'b0;

      if (sample_valid) begin
        hold_l <= lsound_in;
        hold_r <= rsound_in;
      end

      if (frame_start)
        fresh_q <= 1'b0;
      else if (sample_valid)
        fresh_q <= 1'b1;

      if (!tx_en) begin
        div_cnt <= '0;
        bclk_q  <= 1'b0;
        lrck_q  <= 1'b0;
        bit_cnt <= '0;
        shift_q <= '0;
        first_q <= 1'b1;
`ifndef I2S_TX_LJ_EN
        dly_q   <= 1'b0;
`endif
      end else begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
        if (tick)
          bclk_q <= ~bclk_q;

        if (fall) begin
          first_q <= 1'b0;
`ifndef I2S_TX_LJ_EN
          dly_q   <= shift_q[FRAME_W-1];
`endif
          if (frame_start) begin
            bit_cnt <= '0;
            lrck_q  <= 1'b0;
            shift_q <= {slot_l, slot_r};
            req_q   <= 1'b1;
            urun_q  <= !fresh_q && !sample_valid;
          end else begin
            bit_cnt <= next_cnt;
            lrck_q  <= (next_cnt >= CNT_W'(SLOT_WIDTH));
            shift_q <= shift_q << 1;
          end
        end
      end
    end
  end

  assign i2s_bclk   = bclk_q;
  assign i2s_lrck   = lrck_q;
  assign sample_req = req_q;
  assign underrun   = urun_q;
`ifdef I2S_TX_LJ_EN
  assign i2s_data   = shift_q[FRAME_W-1];
`else
  assign i2s_data   = dly_q;
`endif

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - directed/random bench for i2s_audio_tx against a frame-level reference model.
module tb_i2s_audio_tx;

  localparam int SW  = 24;
  localparam int SL  = 32;
  localparam int DIV = 4;
  localparam int FRAME_CLKS = 2 * SL * 2 * DIV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tx_en;
  logic          sample_valid;
  logic [SW-1:0] lsound_in;
  logic [SW-1:0] rsound_in;
  logic          i2s_bclk;
  logic          i2s_lrck;
  logic          i2s_data;
  logic          sample_req;
  logic          underrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [SW-1:0] m_l = '0;
  logic [SW-1:0] m_r = '0;
  logic          m_fresh = 1'b0;
  logic          m_prev = 1'b0;
  int            last_req_cyc = 0;

  i2s_audio_tx #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SL), .BCLK_DIV(DIV)) dut (
    .sCLK_XVXENVS (clk),
    .reset_reg_N  (rst_n),
    .tx_en        (tx_en),
    .sample_valid (sample_valid),
    .lsound_in    (lsound_in),
    .rsound_in    (rsound_in),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_data     (i2s_data),
    .sample_req   (sample_req),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [SW-1:0] l, input logic [SW-1:0] r);
    @(negedge clk);
    lsound_in = l;
    rsound_in = r;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    m_l = l;
    m_r = r;
    m_fresh = 1'b1;
  endtask

  task automatic first_rise(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i2s_bclk && n < 50);
  endtask

  // Waits for the frame-load pulse, then records lrck/data seen at each of the next nbits BCLK rises.
  task automatic get_frame(input int nbits, output logic [63:0] gd, output logic [63:0] gl,
                           output logic urun, output logic ok, output int rc, output int xr);
    int n;
    int cnt;
    logic pb;
    gd = '0; gl = '0; urun = 1'b0; ok = 1'b0; rc = 0; xr = 0;
    n = 0;
    do begin
      @(negedge clk);
      sample_valid = 1'b0;
      n++;
    end while (!sample_req && n < 2000);
    if (!sample_req) return;
    urun = underrun;
    rc = cyc;
    pb = i2s_bclk;
    cnt = 0;
    n = 0;
    while (cnt < nbits && n < 1000) begin
      @(negedge clk);
      n++;
      if (sample_req) xr++;
      if (i2s_bclk && !pb) begin
        gd[cnt] = i2s_data;
        gl[cnt] = i2s_lrck;
        cnt++;
      end
      pb = i2s_bclk;
    end
    ok = (cnt == nbits);
  endtask

  task automatic run_frame(input string tag, input int nbits, input logic exp_urun);
    logic [63:0] w, ed, el, gd, gl, mask;
    logic u, ok;
    int rc, xr;
    w = {m_l, 8'h00, m_r, 8'h00};
    for (int i = 0; i < 64; i++) begin
      el[i] = (i >= SL);
`ifdef I2S_TX_LJ_EN
      ed[i] = w[63-i];
`else
      if (i == 0) ed[i] = m_prev;
      else        ed[i] = w[64-i];
`endif
    end
    get_frame(nbits, gd, gl, u, ok, rc, xr);
    mask = (nbits >= 64) ? '1 : ((64'd1 << nbits) - 64'd1);
    check({tag, "_complete"}, 64'(ok), 64'd1);
    check({tag, "_underrun"}, 64'(u), 64'(exp_urun));
    check({tag, "_data"}, gd & mask, ed & mask);
    check({tag, "_lrck"}, gl & mask, el & mask);
    check({tag, "_extra_req"}, 64'(xr), 64'd0);
    last_req_cyc = rc;
    m_prev = w[0];
    m_fresh = 1'b0;
  endtask

  initial begin
    int n;
    int prev_rc;
    logic [SW-1:0] l, r;

    rst_n = 1'b0;
    tx_en = 1'b1;
    sample_valid = 1'b0;
    lsound_in = '0;
    rsound_in = '0;

    repeat (6) @(negedge clk);
    check("reset_outputs", 64'({i2s_bclk, i2s_lrck, i2s_data, sample_req, underrun}), 64'd0);

    rst_n = 1'b1;
    first_rise(n);
    check("reset_first_rise", 64'(n), 64'(DIV));

    strobe(24'hA5A5A5, 24'h5A5A5A);
    run_frame("pattern", 64, 1'b0);

    // Back-to-back random frames, also checking frame-load spacing.
    for (int k = 0; k < 4; k++) begin
      prev_rc = last_req_cyc;
      l = SW'($urandom());
      r = SW'($urandom());
      strobe(l, r);
      run_frame("random", 64, 1'b0);
      check("req_spacing", 64'(last_req_cyc - prev_rc), 64'(FRAME_CLKS));
    end

    run_frame("underrun1", 64, 1'b1);
    run_frame("underrun2", 64, 1'b1);
    strobe(SW'($urandom()), SW'($urandom()));
    run_frame("recover", 64, 1'b0);

    // Strobe exactly on the frame-start clock: fall lands DIV clocks after the last rise.
    repeat (DIV - 1) @(negedge clk);
    lsound_in = 24'h7FFFFF;
    rsound_in = SW'($urandom());
    sample_valid = 1'b1;
    m_l = lsound_in;
    m_r = rsound_in;
    run_frame("collision", 64, 1'b0);

    l = SW'($urandom()) | 24'h000010;
    strobe(l, SW'($urandom()));
    run_frame("abort_pre", 21, 1'b0);
    check("abort_bclk_high", 64'(i2s_bclk), 64'd1);
    tx_en = 1'b0;
    @(negedge clk);
    check("abort_outputs", 64'({i2s_bclk, i2s_lrck, i2s_data}), 64'd0);
    m_prev = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_outputs", 64'({i2s_bclk, i2s_lrck, i2s_data, sample_req, underrun}), 64'd0);

    tx_en = 1'b1;
    first_rise(n);
    check("reenable_first_rise", 64'(n), 64'(DIV));
    run_frame("reenable", 64, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
